// File: rtl/tag_arb_pkg.sv
// tag_arb_pkg: shared widths, types and round-robin helper for tag_stream_arbiter
package tag_arb_pkg;
  localparam int TAG_W = 11;
  localparam int CT_W = 9;
  localparam int MAX_SRC = 8;
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [CT_W-1:0]  ct;
  } tag_ct_t;
  typedef logic [$clog2(MAX_SRC)-1:0] src_idx_t;
  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_t;
  // First set bit of mask scanning last+1, last+2, ... modulo n; returns last when mask is empty
  function automatic src_idx_t rr_next(input logic [MAX_SRC-1:0] mask, input src_idx_t last, input int n);
    src_idx_t pick;
    src_idx_t j;
    pick = last;
    for (int k = MAX_SRC; k >= 1; k--) begin
      j = src_idx_t'((int'(last) + k) % n);
      if (k <= n && mask[j]) pick = j;
    end
    return pick;
  endfunction
endpackage

// File: rtl/tag_stream_arbiter_if.sv
// tag_stream_arbiter_if: per-source request/ack bundle plus the registered output handshake
interface tag_stream_arbiter_if #(
  parameter int NSRC = 2,
  parameter int Ntag = 11,
  parameter int Nct  = 9
);
  localparam int SW = $clog2(NSRC);
  logic [NSRC-1:0]      in_v;
  logic [NSRC-1:0]      in_a;
  logic [NSRC*Ntag-1:0] in_tag;
  logic [NSRC*Nct-1:0]  in_ct;
  logic                 enable;
  logic                 out_v;
  logic                 out_a;
  logic [Ntag-1:0]      out_tag;
  logic [Nct-1:0]       out_ct;
  logic [SW-1:0]        out_src;
  modport master (output in_v, in_tag, in_ct, enable, out_a, input in_a, out_v, out_tag, out_ct, out_src);
  modport slave (input in_v, in_tag, in_ct, enable, out_a, output in_a, out_v, out_tag, out_ct, out_src);
endinterface

// File: rtl/tag_arb_out_reg.sv
// tag_arb_out_reg: single-entry valid/ack register; a load during a drain replaces the word in place
module tag_arb_out_reg #(
  parameter int W = 21
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         out_a,
  output logic         out_v,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_v <= 1'b0;
      q <= '0;
    end else begin
      out_v <= load | (out_v & ~out_a);
      if (load) q <= d;
    end
  end
endmodule

// File: rtl/tag_stream_arbiter.sv
// tag_stream_arbiter: round-robin arbiter with bounded bursts sharing one tag/count consumer.
// Define TAG_ARB_STATS_EN to add per-source word counters and an output stall counter.
module tag_stream_arbiter
  import tag_arb_pkg::*;
#(
  parameter int Ntag = TAG_W,
  parameter int Nct = CT_W,
  parameter int NSRC = 2,
  parameter int MAX_BURST = 4
) (
  input logic clk,
  input logic reset,
  tag_stream_arbiter_if.slave bus
`ifdef TAG_ARB_STATS_EN
  ,
  input  logic                 stats_clr,
  output logic [NSRC*16-1:0]   word_cnt,
  output logic [15:0]          stall_cnt
`endif
);
  localparam int SW = $clog2(NSRC);
  localparam int W = Ntag + Nct + SW;
  lock_t lock, lock_n;
  logic [SW-1:0] cur, cur_n, last, last_n, g;
  logic [7:0] burst_cnt, burst_n;
  logic can_load, any_v, xfer, at_max;
  logic [W-1:0] q;
  assign can_load = ~bus.out_v | bus.out_a;
  assign g = lock == LOCKED ? cur : SW'(rr_next(MAX_SRC'(bus.in_v), src_idx_t'(last), NSRC));
  assign any_v = lock == LOCKED ? bus.in_v[cur] : |bus.in_v;
  assign xfer = reset & bus.enable & can_load & any_v;
  assign bus.in_a = xfer ? NSRC'(1) << g : '0;
  assign at_max = 9'(burst_cnt) + 9'd1 >= 9'(MAX_BURST);
  // Everything freezes while enable is low so a held burst resumes where it stopped
  always_comb begin
    lock_n = lock;
    cur_n = cur;
    burst_n = burst_cnt;
    last_n = last;
    if (bus.enable) begin
      if (lock == UNLOCKED) begin
        if (xfer) begin
          lock_n = MAX_BURST > 1 ? LOCKED : UNLOCKED;
          cur_n = g;
          burst_n = 8'd1;
          last_n = MAX_BURST > 1 ? last : g;
        end
      end else if (!bus.in_v[cur] || (xfer && at_max)) begin
        lock_n = UNLOCKED;
        last_n = cur;
      end else if (xfer) begin
        burst_n = burst_cnt + 8'd1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      lock <= UNLOCKED;
      cur <= '0;
      burst_cnt <= '0;
      last <= SW'(NSRC - 1);
    end else begin
      lock <= lock_n;
      cur <= cur_n;
      burst_cnt <= burst_n;
      last <= last_n;
    end
  end
  tag_arb_out_reg #(.W(W)) u_out (
    .clk(clk),
    .reset(reset),
    .load(xfer),
    .d({bus.in_tag[g*Ntag +: Ntag], bus.in_ct[g*Nct +: Nct], g}),
    .out_a(bus.out_a),
    .out_v(bus.out_v),
    .q(q)
  );
  assign {bus.out_tag, bus.out_ct, bus.out_src} = q;
`ifdef TAG_ARB_STATS_EN
  always_ff @(posedge clk) begin
    for (int i = 0; i < NSRC; i++)
      if (!reset || stats_clr) word_cnt[i*16 +: 16] <= '0;
      else if (bus.in_a[i] && word_cnt[i*16 +: 16] != 16'hFFFF) word_cnt[i*16 +: 16] <= word_cnt[i*16 +: 16] + 16'd1;
  end
  always_ff @(posedge clk) begin
    if (!reset) stall_cnt <= '0;
    else if (bus.out_v && !bus.out_a && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_tag_stream_arbiter.sv
// tb_tag_stream_arbiter: directed scoreboard bench for tag_stream_arbiter (NSRC=2, MAX_BURST=4)
module tb_tag_stream_arbiter;
  import tag_arb_pkg::*;
  typedef struct packed {
    tag_ct_t w;
    logic    src;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  tag_stream_arbiter_if #(.NSRC(2), .Ntag(TAG_W), .Nct(CT_W)) bus ();
`ifdef TAG_ARB_STATS_EN
  logic stats_clr = 1'b0;
  logic [31:0] word_cnt;
  logic [15:0] stall_cnt;
`endif
  tag_stream_arbiter #(.Ntag(TAG_W), .Nct(CT_W), .NSRC(2), .MAX_BURST(4)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef TAG_ARB_STATS_EN
    ,
    .stats_clr(stats_clr),
    .word_cnt(word_cnt),
    .stall_cnt(stall_cnt)
`endif
  );
  int ncmp = 0;
  int nerr = 0;
  int nout = 0;
  int acks[2];
  logic [1:0] act;
  tag_ct_t srcq[2][$];
  exp_t sbq[$];
  int alog[$];
  int osrc[$];

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic load(input int s, input int n, input int base);
    tag_ct_t w;
    for (int k = 0; k < n; k++) begin
      w.tag = TAG_W'(base + k);
      w.ct = CT_W'(3 * k + s + 1);
      srcq[s].push_back(w);
    end
  endtask

  function automatic int pending();
    return sbq.size() + (act[0] ? srcq[0].size() : 0) + (act[1] ? srcq[1].size() : 0);
  endfunction

  // One cycle: drive sources, sample handshakes before the edge, update scoreboard, advance to next negedge
  task automatic tick();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      bus.in_v[i] = act[i] && srcq[i].size() > 0;
      bus.in_tag[i*TAG_W +: TAG_W] = srcq[i].size() > 0 ? srcq[i][0].tag : '0;
      bus.in_ct[i*CT_W +: CT_W] = srcq[i].size() > 0 ? srcq[i][0].ct : '0;
    end
    #1;
    alog.push_back(int'(bus.in_a));
    chk("ack_onehot", 32'($countones(bus.in_a) <= 1), 1);
    for (int i = 0; i < 2; i++)
      if (bus.in_a[i]) begin
        if (!bus.in_v[i]) chk($sformatf("ack_without_valid%0d", i), 1, 0);
        else begin
          e.w = srcq[i].pop_front();
          e.src = 1'(i);
          sbq.push_back(e);
          acks[i]++;
        end
      end
    if (reset && bus.out_v && bus.out_a) begin
      if (sbq.size() == 0) chk("spurious_out", 1, 0);
      else begin
        e = sbq.pop_front();
        chk("out_word", {bus.out_tag, bus.out_ct, bus.out_src}, e);
        osrc.push_back(int'(bus.out_src));
        nout++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start();
    reset = 1'b0;
    tick();
    chk("rst_in_a", bus.in_a, 0);
    chk("rst_out_v", bus.out_v, 0);
    sbq.delete();
    srcq[0].delete();
    srcq[1].delete();
    reset = 1'b1;
    alog.delete();
    osrc.delete();
    nout = 0;
    acks[0] = 0;
    acks[1] = 0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 80 && pending() > 0; k++) tick();
    chk(name, pending(), 0);
  endtask

  task automatic chk_alog(input string name, input int n, input int e[8]);
    chk({name, "_len"}, 32'(alog.size() >= n), 1);
    for (int k = 0; k < n && k < alog.size(); k++) chk($sformatf("%s_ack[%0d]", name, k), alog[k], e[k]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_v = '0;
    bus.in_tag = '0;
    bus.in_ct = '0;
    bus.enable = 1'b1;
    bus.out_a = 1'b1;
    act = 2'b11;
    acks[0] = 0;
    acks[1] = 0;
    @(negedge clk);
    load(0, 1, 5);
    load(1, 1, 6);
    tick();
    chk("reset_out_v", bus.out_v, 0);
    chk("reset_out_tag", bus.out_tag, 0);
    chk("reset_out_ct", bus.out_ct, 0);
    chk("reset_out_src", bus.out_src, 0);
    chk("reset_in_a", bus.in_a, 0);
    // single source, 10 words, 1 word/cycle, 1-cycle latency
    start();
    act = 2'b01;
    load(0, 10, 0);
    chk("t1_idle_out_v", bus.out_v, 0);
    tick();
    chk("t1_lat_out_v", bus.out_v, 1);
    chk("t1_lat_tag", bus.out_tag, 0);
    repeat (9) tick();
    chk("t1_acks", acks[0], 10);
    tick();
    chk("t1_nout", nout, 10);
    for (int k = 0; k < osrc.size(); k++) chk($sformatf("t1_src[%0d]", k), osrc[k], 0);
    // fairness: both always valid
    start();
    act = 2'b11;
    load(0, 20, 100);
    load(1, 20, 200);
    repeat (32) tick();
    chk("t2_acks0", acks[0], 16);
    chk("t2_acks1", acks[1], 16);
`ifdef TAG_ARB_STATS_EN
    chk("t2_word_cnt", word_cnt, 32'h0010_0010);
`endif
    act = 2'b00;
`ifdef TAG_ARB_STATS_EN
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    chk("t2_word_cnt_clr", word_cnt, 0);
`endif
    drain("t2_drain");
    chk("t2_nout", nout, 32);
    for (int k = 0; k < osrc.size(); k++) chk($sformatf("t2_src[%0d]", k), osrc[k], (k / 4) % 2);
    // backpressure: output full and out_a low for 5 cycles
    start();
    act = 2'b01;
    load(0, 8, 300);
    tick();
    bus.out_a = 1'b0;
    repeat (5) begin
      tick();
      chk("t3_out_v", bus.out_v, 1);
      chk("t3_tag", bus.out_tag, sbq[0].w.tag);
      chk("t3_ct", bus.out_ct, sbq[0].w.ct);
      chk("t3_src", bus.out_src, sbq[0].src);
    end
`ifdef TAG_ARB_STATS_EN
    chk("t3_stall_cnt", stall_cnt, 5);
`endif
    bus.out_a = 1'b1;
    chk_alog("t3", 6, '{1, 0, 0, 0, 0, 0, 0, 0});
    drain("t3_drain");
    chk("t3_nout", nout, 8);
    // burst break: source 1 runs dry after 2 words while locked
    start();
    act = 2'b10;
    load(1, 2, 400);
    load(0, 4, 500);
    tick();
    act = 2'b11;
    tick();
    tick();
    load(1, 4, 600);
    repeat (5) tick();
    chk_alog("t4", 8, '{2, 2, 0, 1, 1, 1, 1, 2});
    drain("t4_drain");
    // enable held low for 3 cycles mid-burst
    start();
    act = 2'b01;
    load(0, 10, 700);
    tick();
    tick();
    bus.enable = 1'b0;
    act = 2'b11;
    load(1, 10, 800);
    repeat (3) tick();
    chk("t5_drained", bus.out_v, 0);
    bus.enable = 1'b1;
    repeat (3) tick();
    chk_alog("t5", 8, '{1, 1, 0, 0, 0, 1, 1, 2});
    drain("t5_drain");
    // reset while locked with the output full
    start();
    act = 2'b10;
    load(1, 6, 900);
    load(0, 6, 1000);
    tick();
    tick();
    chk("t6_full", bus.out_v, 1);
    reset = 1'b0;
    tick();
    sbq.delete();
    chk("t6_out_v", bus.out_v, 0);
    chk("t6_in_a", bus.in_a, 0);
    reset = 1'b1;
    act = 2'b11;
    tick();
    chk_alog("t6", 4, '{2, 2, 0, 1, 0, 0, 0, 0});
    drain("t6_drain");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/tag_stream_arbiter.md
Name: tag_stream_arbiter

Overview:
- Shares the single downstream tag/count consumer between NSRC tag producers: source 0 is the BD tag split tag output, source 1 is host-injected tags, and further sources are optional.
- Round-robin arbitration with bounded bursts.
- One registered output stage: full throughput, and output signals are driven from registers.
- Sits between the tag split stage(s) and the tag accumulator/router.

Parameters:
- Ntag, 11, tag field width
- Nct, 9, count field width
- NSRC, 2, number of requesting sources (2..8)
- MAX_BURST, 4, maximum consecutive words granted to one source before rotation (1..255)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset (0 = reset)
- in_v  input  NSRC  per-source valid
- in_tag  input  NSRC*Ntag  per-source tag; source i occupies bits [i*Ntag +: Ntag]
- in_ct  input  NSRC*Nct  per-source count, packed the same way
- in_a  output  NSRC  per-source ack (combinational)
- enable  input  1  1 = grants allowed; 0 = no new words accepted
- out_v  output  1  registered valid
- out_tag  output  Ntag  registered tag
- out_ct  output  Nct  registered count
- out_src  output  $clog2(NSRC)  index of the source that produced the word
- out_a  input  1  downstream ack

Behaviour:
- Transfer rules: an input transfer occurs when in_v[i] & in_a[i]; an output transfer occurs when out_v & out_a.
- Output register: can_load = ~out_v | out_a.
- Acks: in_a[g] = enable & can_load & in_v[g] for the granted source g only. All other in_a bits are 0. At most one in_a bit is high per cycle.
- Output register load: on an input transfer, the register captures tag, ct and g, and out_v = 1 next cycle. On an output transfer with no input transfer, out_v = 0 next cycle. Otherwise the register holds. While out_v = 1 and out_a = 0, out_tag, out_ct and out_src are stable.
- Latency: 1 cycle from input transfer to out_v. Back-to-back operation sustains 1 word per cycle.
- State register: lock (1b), cur (source index), burst_cnt (8b), last (source index).
- State UNLOCKED (lock = 0): g = first i with in_v[i] = 1, scanning last+1, last+2, ... modulo NSRC. No valid input means no grant.
  - On a transfer from g: lock = 1, cur = g, burst_cnt = 1.
  - If MAX_BURST = 1, the state stays UNLOCKED and last = g.
- State LOCKED (lock = 1): g = cur.
  - A transfer with burst_cnt + 1 < MAX_BURST increments burst_cnt.
  - A transfer with burst_cnt + 1 == MAX_BURST, or any cycle with in_v[cur] = 0, sets lock = 0 and last = cur.
  - When the burst ends because in_v[cur] dropped, the arbitration for the next source happens the following cycle, so a 1-cycle bubble is allowed.
  - A stall (in_v[cur] = 1, can_load = 0) holds all state.
- enable = 0:
  - in_a = 0 and lock/cur/burst_cnt are held.
  - The output register still drains normally.
  - When enable returns to 1, the held burst continues.
- Simultaneous load and drain in the same cycle: the new word replaces the old one and out_v stays 1.
- Reset (reset = 0 at a clk edge):
  - out_v = 0, out_tag = 0, out_ct = 0, out_src = 0.
  - lock = 0, cur = 0, burst_cnt = 0, last = NSRC-1, so source 0 has first priority.
  - in_a = 0 while reset = 0.
  - Reset mid-burst or with the output full discards the held word with no handshake.
- Sources must hold in_v, in_tag and in_ct stable until acked; the arbiter does not check this.

Optional Feature:
- Macro: TAG_ARB_STATS_EN.
- Defined:
  - Adds output port word_cnt (NSRC*16 bits): one 16-bit counter per source, incremented on each input transfer from that source.
  - Counters saturate at 16'hFFFF.
  - Reset to 0; also cleared synchronously by a new input stats_clr = 1, and clear has priority over increment.
  - Adds output port stall_cnt (16 bits): saturating count of cycles with out_v & ~out_a.
- Undefined: these ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- Shared package tag_arb_pkg:
  - localparams TAG_W = 11, CT_W = 9.
  - typedef tag_ct_t, a packed struct {tag, ct}.
  - typedef src_idx_t.
  - function rr_next(mask, last), returning the round-robin pick.
- One sub-module: tag_arb_out_reg. This is the single-entry valid/ack register holding tag, ct and src. The arbiter FSM stays in the top module.

Test Plan:
- Single source: source 0 sends 10 words with tags 0..9; out_a tied to 1; source 1 idle. Required: 10 outputs in order, out_src = 0, 1 word/cycle, first out_v 1 cycle after the first ack.
- Fairness: both sources always valid with MAX_BURST = 4 and out_a = 1. Required: out_src sequence 0,0,0,0,1,1,1,1,0,... and exactly 16 words per source in 32 cycles.
- Backpressure: out_a = 0 for 5 cycles while the output is full. Required: out_tag/out_ct/out_src stable, in_a = 0 for all sources, no word lost or duplicated when out_a returns to 1.
- Burst break: source 1 drops in_v after 2 words while locked, with source 0 valid. Required: at most 1 bubble cycle, then source 0 is granted; burst_cnt restarts at 1.
- enable toggle: enable = 0 for 3 cycles mid-burst. Required: in_a = 0, pending output drains; after enable = 1 the same source resumes and completes the remaining burst words.
- Reset mid-operation: reset = 0 with out_v = 1 and lock = 1. Required: next cycle out_v = 0, in_a = 0; after release, source 0 wins the first contest against source 1.
- With TAG_ARB_STATS_EN defined, the fairness run must show word_cnt = {16, 16}, and stats_clr must zero both counters the next cycle.
